// File: rtl/sram_wr_ctrl.sv
// Write-side data stage of the AXI4 SRAM slave: pairs each generated beat address with a
// W beat, issues a registered byte-masked SRAM write and returns one B response per burst.
module sram_wr_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int SRAM_DEPTH = 1024
) (
  input  logic                          aclk_i,
  input  logic                          areset_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          addr_last_i,
  input  logic                          addr_valid_i,
  output logic                          addr_ready_o,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [DATA_WIDTH/8-1:0]       wstrb_i,
  input  logic                          wlast_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic [1:0]                    bresp_o,
  output logic                          bvalid_o,
  input  logic                          bready_i,
  output logic                          sram_en_o,
  output logic [DATA_WIDTH/8-1:0]       sram_we_o,
  output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o
);
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int OFFS_WIDTH  = $clog2(STRB_WIDTH);
  localparam int SADDR_WIDTH = $clog2(SRAM_DEPTH);

  typedef enum logic {ST_DATA = 1'b0, ST_RESP = 1'b1} state_e;

  state_e                  state_q;
  logic                    err_q;
  logic                    err_d;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic [1:0]              bresp_d;
  logic                    sram_en_q;
  logic [STRB_WIDTH-1:0]   sram_we_q;
  logic [SADDR_WIDTH-1:0]  sram_addr_q;
  logic [DATA_WIDTH-1:0]   sram_wdata_q;
  logic [ADDR_WIDTH-1:0]   word_s;
  logic                    in_range_s;
  logic                    fire_s;
  logic                    beat_err_s;

  assign word_s     = addr_i >> OFFS_WIDTH;
  assign in_range_s = (word_s < ADDR_WIDTH'(SRAM_DEPTH));
  assign fire_s     = (state_q == ST_DATA) && addr_valid_i && wvalid_i;

  // Each ready mirrors the other stream's valid so a beat never splits across cycles.
  always_comb begin
    addr_ready_o = 1'b0;
    wready_o     = 1'b0;
    case (state_q)
      ST_DATA: begin
        addr_ready_o = wvalid_i;
        wready_o     = addr_valid_i;
      end
      ST_RESP: begin
        addr_ready_o = 1'b0;
        wready_o     = 1'b0;
      end
      default: begin
        addr_ready_o = 1'b0;
        wready_o     = 1'b0;
      end
    endcase
  end

  // Fold this beat's range and last-flag errors into the sticky burst error.
  always_comb begin
    beat_err_s = 1'b0;
    if (fire_s) begin
      beat_err_s = !in_range_s || (wlast_i != addr_last_i);
    end else begin
      beat_err_s = 1'b0;
    end
    err_d   = err_q || beat_err_s;
    bresp_d = err_d ? 2'b10 : 2'b00;
  end

  // Burst FSM with registered SRAM command and B response.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q      <= ST_DATA;
      err_q        <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      sram_en_q    <= 1'b0;
      sram_we_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      sram_en_q <= 1'b0;
      sram_we_q <= '0;
      case (state_q)
        ST_DATA: begin
          if (fire_s) begin
            if (in_range_s) begin
              sram_en_q    <= 1'b1;
              sram_we_q    <= wstrb_i;
              sram_addr_q  <= word_s[SADDR_WIDTH-1:0];
              sram_wdata_q <= wdata_i;
            end
            // The address stream alone decides where the burst ends.
            if (addr_last_i) begin
              state_q  <= ST_RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= bresp_d;
            end
            err_q <= err_d;
          end
        end
        ST_RESP: begin
          if (bready_i) begin
            state_q  <= ST_DATA;
            bvalid_q <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_DATA;
          bvalid_q <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bvalid_o     = bvalid_q;
  assign bresp_o      = bresp_q;
  assign sram_en_o    = sram_en_q;
  assign sram_we_o    = sram_we_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;
endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Self-checking bench for sram_wr_ctrl: directed scenarios plus randomized bursts checked
// against a burst-level model (word = addr/8, range test, sticky error, one B per burst).
module tb_sram_wr_ctrl;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int DEPTH = 1024;
  localparam int SW = DW / 8;

  logic          aclk = 1'b0;
  logic          areset_i;
  logic [AW-1:0] addr_i;
  logic          addr_last_i, addr_valid_i, addr_ready_o;
  logic [DW-1:0] wdata_i;
  logic [SW-1:0] wstrb_i;
  logic          wlast_i, wvalid_i, wready_o;
  logic [1:0]    bresp_o;
  logic          bvalid_o, bready_i;
  logic          sram_en_o;
  logic [SW-1:0] sram_we_o;
  logic [9:0]    sram_addr_o;
  logic [DW-1:0] sram_wdata_o;

  always #5 aclk = ~aclk;

  sram_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH)) dut (
    .aclk_i(aclk), .areset_i(areset_i),
    .addr_i(addr_i), .addr_last_i(addr_last_i), .addr_valid_i(addr_valid_i), .addr_ready_o(addr_ready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o)
  );

  int checks = 0;
  int errors = 0;

  int            n_beats;
  logic [AW-1:0] b_addr [16];
  logic [DW-1:0] b_data [16];
  logic [SW-1:0] b_strb [16];
  logic          b_wlast[16];

  // Expected registered SRAM command, as produced by the model one edge earlier.
  logic          exp_en;
  logic [SW-1:0] exp_we;
  logic [9:0]    exp_addr;
  logic [DW-1:0] exp_data;

  task automatic run_burst(input string tag, input int gapmax, input int wdelay, input int bhold);
    int i, pre, gaps;
    logic av, wv, berr;
    logic [1:0] exp_resp;
    i = 0; pre = wdelay; gaps = 0; berr = 1'b0;
    while (i < n_beats) begin
      if (pre > 0) begin
        av = 1'b1; wv = 1'b0; pre--;
      end else if (gaps > 0) begin
        av = 1'($urandom_range(0, 1));
        wv = av ? 1'b0 : 1'($urandom_range(0, 1));
        gaps--;
      end else begin
        av = 1'b1; wv = 1'b1;
      end
      addr_valid_i = av; wvalid_i = wv;
      addr_i = b_addr[i]; addr_last_i = (i == n_beats - 1);
      wdata_i = b_data[i]; wstrb_i = b_strb[i]; wlast_i = b_wlast[i];
      bready_i = 1'($urandom_range(0, 1));
      @(negedge aclk);
      checks++; if (addr_ready_o !== wv) begin errors++; $display("FAIL %s addr_ready: got %b exp %b", tag, addr_ready_o, wv); end
      checks++; if (wready_o !== av) begin errors++; $display("FAIL %s wready: got %b exp %b", tag, wready_o, av); end
      checks++; if (bvalid_o !== 1'b0) begin errors++; $display("FAIL %s bvalid_in_data: got %b exp 0", tag, bvalid_o); end
      checks++; if (sram_en_o !== exp_en || sram_we_o !== exp_we) begin errors++; $display("FAIL %s sram_en_we: got %b/%h exp %b/%h", tag, sram_en_o, sram_we_o, exp_en, exp_we); end
      if (exp_en) begin
        checks++; if (sram_addr_o !== exp_addr || sram_wdata_o !== exp_data) begin errors++; $display("FAIL %s sram_addr_data: got %h/%h exp %h/%h", tag, sram_addr_o, sram_wdata_o, exp_addr, exp_data); end
      end
      @(posedge aclk); #1;
      if (av && wv) begin
        if (b_addr[i] / 8 < DEPTH) begin
          exp_en = 1'b1; exp_we = b_strb[i]; exp_addr = 10'(b_addr[i] / 8); exp_data = b_data[i];
        end else begin
          exp_en = 1'b0; exp_we = '0; berr = 1'b1;
        end
        if (b_wlast[i] != (i == n_beats - 1)) berr = 1'b1;
        i++;
        gaps = $urandom_range(0, gapmax);
      end else begin
        exp_en = 1'b0; exp_we = '0;
      end
    end
    exp_resp = berr ? 2'b10 : 2'b00;
    for (int k = 0; k <= bhold; k++) begin
      addr_valid_i = 1'($urandom_range(0, 1)); wvalid_i = 1'($urandom_range(0, 1));
      bready_i = (k == bhold);
      @(negedge aclk);
      checks++; if (bvalid_o !== 1'b1) begin errors++; $display("FAIL %s bvalid: got %b exp 1 (resp cycle %0d)", tag, bvalid_o, k); end
      checks++; if (bresp_o !== exp_resp) begin errors++; $display("FAIL %s bresp: got %b exp %b", tag, bresp_o, exp_resp); end
      checks++; if (addr_ready_o !== 1'b0 || wready_o !== 1'b0) begin errors++; $display("FAIL %s readies_in_resp: got %b%b exp 00", tag, addr_ready_o, wready_o); end
      checks++; if (sram_en_o !== exp_en || sram_we_o !== exp_we) begin errors++; $display("FAIL %s resp_sram_en_we: got %b/%h exp %b/%h", tag, sram_en_o, sram_we_o, exp_en, exp_we); end
      if (exp_en) begin
        checks++; if (sram_addr_o !== exp_addr || sram_wdata_o !== exp_data) begin errors++; $display("FAIL %s last_addr_data: got %h/%h exp %h/%h", tag, sram_addr_o, sram_wdata_o, exp_addr, exp_data); end
      end
      @(posedge aclk); #1;
      exp_en = 1'b0; exp_we = '0;
    end
    addr_valid_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
  endtask

  task automatic fill_random(input int n);
    int word;
    n_beats = n;
    for (int i = 0; i < n; i++) begin
      word = ($urandom_range(0, 19) == 0) ? DEPTH + $urandom_range(0, 63) : $urandom_range(0, DEPTH - 1);
      b_addr[i]  = AW'(word * 8 + $urandom_range(0, 7));
      b_data[i]  = {$urandom, $urandom};
      b_strb[i]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b_wlast[i] = (i == n - 1) ^ ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic test_reset;
    areset_i = 1'b1; addr_valid_i = 1'b1; wvalid_i = 1'b1; addr_last_i = 1'b1; wlast_i = 1'b1;
    addr_i = 32'h0000_0040; wdata_i = 64'hDEAD_BEEF_0000_0001; wstrb_i = 8'hFF; bready_i = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (sram_en_o !== 1'b0 || sram_we_o !== 8'h00) begin errors++; $display("FAIL reset_sram_en: got %b/%h exp 0/00", sram_en_o, sram_we_o); end
    checks++; if (sram_addr_o !== 10'h000 || sram_wdata_o !== 64'h0) begin errors++; $display("FAIL reset_sram_addr: got %h/%h exp 0/0", sram_addr_o, sram_wdata_o); end
    checks++; if (bvalid_o !== 1'b0 || bresp_o !== 2'b00) begin errors++; $display("FAIL reset_b: got %b/%b exp 0/00", bvalid_o, bresp_o); end
    @(posedge aclk); #1;
    areset_i = 1'b0; addr_valid_i = 1'b0; wvalid_i = 1'b0;
    exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_data = '0;
  endtask

  task automatic test_burst4;
    n_beats = 4;
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = 32'h100 + 32'(i * 8); b_data[i] = {$urandom, $urandom};
      b_strb[i] = 8'hFF; b_wlast[i] = (i == 3);
    end
    run_burst("burst4", 0, 0, 0);
  endtask

  task automatic test_w_delay;
    fill_random(2);
    b_addr[0] = 32'h0000_1238; b_addr[1] = 32'h0000_1240; b_wlast[0] = 1'b0; b_wlast[1] = 1'b1;
    run_burst("w_delay", 0, 3, 0);
  endtask

  task automatic test_out_of_range;
    fill_random(2);
    b_addr[0] = 32'h0000_1FF8; b_addr[1] = 32'h0000_2000; b_wlast[0] = 1'b0; b_wlast[1] = 1'b1;
    run_burst("oor", 0, 0, 0);
    fill_random(1);
    b_addr[0] = 32'h0000_0008; b_wlast[0] = 1'b1;
    run_burst("after_oor", 0, 0, 0);
  endtask

  task automatic test_wlast_mismatch;
    fill_random(2);
    b_addr[0] = 32'h0000_0300; b_addr[1] = 32'h0000_0308; b_wlast[0] = 1'b1; b_wlast[1] = 1'b1;
    run_burst("wlast_mismatch", 0, 0, 0);
  endtask

  task automatic test_bready_hold;
    fill_random(1);
    b_addr[0] = 32'h0000_0010; b_wlast[0] = 1'b1;
    run_burst("bready_hold", 0, 0, 5);
    fill_random(1);
    b_addr[0] = 32'h0000_0018; b_wlast[0] = 1'b1;
    run_burst("after_hold", 0, 0, 0);
  endtask

  task automatic test_reset_mid_burst;
    fill_random(4);
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = 32'h200 + 32'(i * 8); b_wlast[i] = (i == 3);
    end
    addr_valid_i = 1'b1; wvalid_i = 1'b1; addr_last_i = 1'b0;
    addr_i = b_addr[0]; wdata_i = b_data[0]; wstrb_i = b_strb[0]; wlast_i = 1'b0;
    @(posedge aclk); #1;
    addr_i = b_addr[1]; wdata_i = b_data[1]; wstrb_i = b_strb[1]; areset_i = 1'b1;
    @(negedge aclk);
    checks++; if (sram_en_o !== 1'b1 || sram_addr_o !== 10'h040) begin errors++; $display("FAIL rst_mid_beat1: got %b/%h exp 1/040", sram_en_o, sram_addr_o); end
    @(posedge aclk); #1;
    areset_i = 1'b0; addr_valid_i = 1'b0; wvalid_i = 1'b0;
    @(negedge aclk);
    checks++; if (sram_en_o !== 1'b0 || sram_we_o !== 8'h00 || sram_addr_o !== 10'h000 || sram_wdata_o !== 64'h0) begin errors++; $display("FAIL rst_mid_sram: got %b/%h/%h/%h exp all 0", sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o); end
    checks++; if (bvalid_o !== 1'b0 || bresp_o !== 2'b00) begin errors++; $display("FAIL rst_mid_b: got %b/%b exp 0/00", bvalid_o, bresp_o); end
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      wvalid_i = 1'b1; addr_valid_i = 1'b0;
      @(negedge aclk);
      checks++; if (bvalid_o !== 1'b0 || addr_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got bvalid %b addr_ready %b exp 0/1", bvalid_o, addr_ready_o); end
    end
    @(posedge aclk); #1;
    wvalid_i = 1'b0;
    exp_en = 1'b0; exp_we = '0;
    fill_random(1);
    b_addr[0] = 32'h0000_0020; b_wlast[0] = 1'b1;
    run_burst("after_rst", 0, 0, 0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 30; r++) begin
      fill_random($urandom_range(1, 8));
      run_burst("random", 2, 0, $urandom_range(0, 3));
    end
  endtask

  initial begin
    areset_i = 1'b1; addr_valid_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
    addr_i = '0; addr_last_i = 1'b0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0;
    exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_data = '0;
    test_reset();
    test_burst4();
    test_w_delay();
    test_out_of_range();
    test_wlast_mismatch();
    test_bready_hold();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
